// File: rtl/latch_load_ctrl.sv
// Write sequencer for an async-reset D-latch bank: accepts a word on valid/ready,
// then times setup, enable-open and hold windows with one shared down-counter.
module latch_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             rst,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] OPEN_LD  = 4'(OPEN_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             en_q;
  logic             rst_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  // NOTE: every state flop uses <= so all updates see the pre-edge values;
  // blocking assignments here would let later lines read already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      d_q     <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rst_q) begin
        // One clean clock of latch reset after release, then open for business.
        rst_q   <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (in_valid && ready_q) begin
              d_q     <= in_data;
              cnt_q   <= SETUP_LD;
              state_q <= SETUP;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          SETUP: begin
            if (cnt_q == 4'd0) begin
              cnt_q   <= OPEN_LD;
              en_q    <= 1'b1;
              state_q <= OPEN;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          OPEN: begin
            if (cnt_q == 4'd0) begin
              cnt_q   <= HOLD_LD;
              en_q    <= 1'b0;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          HOLD: begin
            if (cnt_q == 4'd0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready = ready_q;
  assign d        = d_q;
  assign en       = en_q;
  assign rst      = rst_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_latch_load_ctrl.sv
// Directed bench for latch_load_ctrl: default-parameter instance plus a
// SETUP=3/OPEN=1/HOLD=2 instance for the timing sweep.
module tb_latch_load_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_valid2;
  logic [7:0] in_data;

  logic       in_ready, en, rst, busy, done;
  logic [7:0] d;
  logic       in_ready2, en2, rst2, busy2, done2;
  logic [7:0] d2;

  int total;
  int bad;

  latch_load_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .d(d), .en(en), .rst(rst), .busy(busy), .done(done)
  );

  latch_load_ctrl #(.WIDTH(8), .SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(2)) u_sweep (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data),
    .in_ready(in_ready2), .d(d2), .en(en2), .rst(rst2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bounded wait for in_ready on either instance; an expired bound counts as a failure.
  task automatic wait_ready(input bit sweep);
    int n;
    n = 0;
    while (((sweep ? in_ready2 : in_ready) !== 1'b1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL wait_ready sweep=%0d: in_ready never rose within 50 clocks", sweep);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if ({rst, en, d, in_ready, busy, done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold: rst=%b en=%b d=%h rdy=%b busy=%b done=%b, want 1 0 00 0 0 0",
                 rst, en, d, in_ready, busy, done);
      end
    end
    rst_n = 1'b1;
    #2;
    total++;
    if (rst !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_pre_edge: rst=%b rdy=%b, want 1 0", rst, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (rst !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_edge: rst=%b rdy=%b busy=%b done=%b, want 0 1 0 0",
               rst, in_ready, busy, done);
    end
    total++;
    if (rst2 !== 1'b0 || in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_sweep: rst=%b rdy=%b, want 0 1", rst2, in_ready2);
    end
  endtask

  task automatic test_single;
    logic [5:0] en_exp, busy_exp, done_exp, rdy_exp;
    en_exp   = 6'b000110;
    busy_exp = 6'b001111;
    done_exp = 6'b010000;
    rdy_exp  = 6'b110000;
    wait_ready(1'b0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      total++;
      if (d !== 8'hA5 || en !== en_exp[k] || busy !== busy_exp[k] ||
          done !== done_exp[k] || in_ready !== rdy_exp[k]) begin
        bad++;
        $display("FAIL single_edge%0d: d=%h en=%b busy=%b done=%b rdy=%b, want A5 %b %b %b %b",
                 k, d, en, busy, done, in_ready, en_exp[k], busy_exp[k], done_exp[k], rdy_exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic       prev_en;
    logic [7:0] prev_d;
    int second_at, pulses, width, w_bad, d_bad;
    wait_ready(1'b0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(posedge clk); #1;
    total++;
    if (d !== 8'h3C) begin
      bad++;
      $display("FAIL b2b_first_accept: d=%h, want 3C", d);
    end
    in_data   = 8'hC3;
    prev_en   = en;
    prev_d    = d;
    second_at = -1;
    pulses    = 0;
    width     = 0;
    w_bad     = 0;
    d_bad     = 0;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk); #1;
      if (d !== prev_d && (en || prev_en)) d_bad++;
      if (d === 8'hC3 && second_at < 0) begin
        second_at = k;
        in_valid  = 1'b0;
      end
      if (en) begin
        width++;
      end else if (prev_en) begin
        pulses++;
        if (width != 2) w_bad++;
        width = 0;
      end
      prev_en = en;
      prev_d  = d;
    end
    in_valid = 1'b0;
    total++;
    if (second_at != 5) begin
      bad++;
      $display("FAIL b2b_spacing: second accept at edge %0d, want 5", second_at);
    end
    total++;
    if (pulses != 2) begin
      bad++;
      $display("FAIL b2b_pulses: %0d en pulses, want 2", pulses);
    end
    total++;
    if (w_bad != 0) begin
      bad++;
      $display("FAIL b2b_width: %0d pulses not 2 clocks wide, want 0", w_bad);
    end
    total++;
    if (d_bad != 0) begin
      bad++;
      $display("FAIL b2b_d_stable: d changed %0d times near en high, want 0", d_bad);
    end
  endtask

  task automatic test_valid_while_busy;
    wait_ready(1'b0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (en !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_open: en=%b, want 1", en);
    end
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int k = 2; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (d !== 8'hA5 || in_ready !== (k == 4)) begin
        bad++;
        $display("FAIL busy_no_accept_edge%0d: d=%h rdy=%b, want A5 %b", k, d, in_ready, k == 4);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (d !== 8'hFF || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL busy_late_accept: d=%h busy=%b rdy=%b, want FF 1 0", d, busy, in_ready);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_open;
    wait_ready(1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (en !== 1'b1 || d !== 8'h5A) begin
      bad++;
      $display("FAIL midrst_pre: en=%b d=%h, want 1 5A", en, d);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({en, rst, d, in_ready, busy, done} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_async: en=%b rst=%b d=%h rdy=%b busy=%b done=%b, want 0 1 00 0 0 0",
               en, rst, d, in_ready, busy, done);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rst, in_ready, done, en, busy} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_release: rst=%b rdy=%b done=%b en=%b busy=%b, want 0 1 0 0 0",
               rst, in_ready, done, en, busy);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || d !== 8'h00) begin
      bad++;
      $display("FAIL midrst_idle: done=%b busy=%b d=%h, want 0 0 00", done, busy, d);
    end
  endtask

  task automatic test_param_sweep;
    logic [7:0] en_exp, busy_exp, done_exp, rdy_exp;
    en_exp   = 8'b00001000;
    busy_exp = 8'b00111111;
    done_exp = 8'b01000000;
    rdy_exp  = 8'b11000000;
    wait_ready(1'b1);
    in_valid2 = 1'b1;
    in_data   = 8'h96;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      total++;
      if (d2 !== 8'h96 || en2 !== en_exp[k] || busy2 !== busy_exp[k] ||
          done2 !== done_exp[k] || in_ready2 !== rdy_exp[k]) begin
        bad++;
        $display("FAIL sweep_edge%0d: d=%h en=%b busy=%b done=%b rdy=%b, want 96 %b %b %b %b",
                 k, d2, en2, busy2, done2, in_ready2, en_exp[k], busy_exp[k], done_exp[k], rdy_exp[k]);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_data   = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_open();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
